adder_tree_stream: RTL
======================

ADDER_TREE_STREAM -- requirements
Module: adder_tree_stream

Interface
REQ-001 SHALL have parameter INPUT_NUM, default 18: number of signed lanes summed (>=2).
REQ-002 SHALL have parameter IN_WIDTH, default 12: signed width of each lane.
REQ-003 SHALL have parameter OUT_WIDTH, default IN_WIDTH+$clog2(INPUT_NUM): signed width of dout (1..ACC_W+1).
REQ-004 SHALL have parameter SHIFT, default 15: arithmetic right-shift amount used in SHIFT mode.
REQ-005 SHALL have port clk, input, 1: clock, all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port din, input, INPUT_NUM*IN_WIDTH: lane k at bits [(k+1)*IN_WIDTH-1 -: IN_WIDTH].
REQ-008 SHALL have port in_valid, input, 1: din/mode valid.
REQ-009 SHALL have port in_ready, output, 1: block accepts a sample this cycle.
REQ-010 SHALL have port mode, input, 2: per-sample mode, 0 NORMAL, 1 ABS, 2 SHIFT, 3 treated as NORMAL.
REQ-011 SHALL have port dout, output, OUT_WIDTH: signed result.
REQ-012 SHALL have port out_valid, output, 1: dout valid.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts dout.
REQ-014 SHALL have port out_sat, output, 1: dout was clamped (qualified by out_valid).

Function
REQ-015 STAGE_NUM = $clog2(INPUT_NUM); ACC_W = IN_WIDTH+STAGE_NUM; every tree node SHALL be ACC_W bits, lanes sign-extended.
REQ-016 Leaves INPUT_NUM..2^STAGE_NUM-1 SHALL be constant zero, never X.
REQ-017 Pipeline: input register, STAGE_NUM registered adder stages, one output register (mode + clamp); latency SHALL be STAGE_NUM+2 cycles from accepted sample to out_valid.
REQ-018 mode SHALL be captured with din and carried per stage; mode changes never affect in-flight samples.
REQ-019 A valid bit SHALL travel with each stage; bubbles (in_valid=0) SHALL produce no out_valid.
REQ-020 Stall = out_valid & ~out_ready; on stall every stage (data, mode, valid) SHALL hold; in_ready = ~stall (combinational).
REQ-021 Sample accepted iff in_valid & in_ready; out_valid/dout/out_sat SHALL stay stable while stalled; no sample lost or duplicated.
REQ-022 ABS SHALL compute |sum| in ACC_W+1 bits, so -2^(ACC_W-1) yields +2^(ACC_W-1) before clamp.
REQ-023 SHIFT SHALL be arithmetic (floor toward -inf): sum >>> SHIFT.
REQ-024 Result SHALL be clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; out_sat=1 iff clamped (see REQ-029).
REQ-025 out_ready=1 with in_valid=1 every cycle SHALL sustain throughput of one sample per cycle.

Reset
REQ-026 rst_n low SHALL asynchronously clear all stage data, mode and valid bits to 0.
REQ-027 During and after reset dout=0, out_valid=0, out_sat=0, in_ready=1.
REQ-028 Reset mid-stream SHALL discard all in-flight samples; first output after release comes from a sample accepted after release.

Configuration
REQ-029 Macro ADDER_TREE_STREAM_SAT_EN: defined -> clamp per REQ-024; undefined -> result truncated to low OUT_WIDTH bits (two's-complement wrap), out_sat tied 0, no comparator logic.

Verification (defaults, latency 7, unless stated)
REQ-030 All lanes +1, mode 0, one beat -> dout=18, out_valid exactly 7 cycles after acceptance, single cycle.
REQ-031 All lanes -2048, mode 1 -> dout=36864, out_sat=0.
REQ-032 OUT_WIDTH=12, all lanes 2047, mode 0 -> with SAT_EN dout=2047, out_sat=1; without dout=-18, out_sat=0.
REQ-033 Lane0=-100, others 0, mode 2, SHIFT=4 -> dout=-7.
REQ-034 Continuous stream of 20 distinct samples, out_ready low 3 cycles mid-stream -> in_ready low same cycles, dout held, all 20 results in order, none duplicated.
REQ-035 Assert rst_n low with 5 samples in flight -> outputs 0 immediately; after release no stale out_valid.

Source files
------------

// File: rtl/adder_tree_stream.sv
// adder_tree_stream: streaming signed adder tree with per-sample post-processing.
//
// Sums INPUT_NUM signed lanes of IN_WIDTH bits through a registered binary tree,
// then applies a per-sample mode (NORMAL / ABS / arithmetic SHIFT). The result is
// either clamped to OUT_WIDTH or wrapped to OUT_WIDTH, depending on the build.
// The pipeline is an input register, $clog2(INPUT_NUM) adder stages and one
// output register. A downstream stall freezes the whole pipeline.
//
// Build option:
//   ADDER_TREE_STREAM_SAT_EN  defined   -> saturate to the OUT_WIDTH range, out_sat flags it
//                             undefined -> keep the low OUT_WIDTH bits (wrap), out_sat = 0
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   din        packed lanes, lane k at [(k+1)*IN_WIDTH-1 -: IN_WIDTH]
//   in_valid   din/mode valid
//   in_ready   pipeline accepts a sample this cycle
//   mode       0 NORMAL, 1 ABS, 2 SHIFT, 3 NORMAL
//   dout       signed result
//   out_valid  dout valid
//   out_ready  downstream accepts dout
//   out_sat    dout was clamped (qualified by out_valid)
module adder_tree_stream #(
    parameter int INPUT_NUM = 18,
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = IN_WIDTH + $clog2(INPUT_NUM),
    parameter int SHIFT     = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [INPUT_NUM*IN_WIDTH-1:0] din,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    mode,
    output logic signed [OUT_WIDTH-1:0]   dout,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sat
);

    localparam int STAGE_NUM = $clog2(INPUT_NUM);
    localparam int ACC_W     = IN_WIDTH + STAGE_NUM;
    localparam int LEAF_NUM  = 1 << STAGE_NUM;
    localparam int NODE_NUM  = 2 * LEAF_NUM - 1;
    localparam int LEAF_BASE = LEAF_NUM - 1;

    // Heap-ordered tree: node j has children 2j+1 and 2j+2, node 0 is the root.
    // Every heap level is one pipeline register stage; the leaves are the input register.
    logic signed [ACC_W-1:0] node_q [NODE_NUM];
    logic [1:0]              mode_q [STAGE_NUM+1];
    logic [STAGE_NUM:0]      valid_q;

    logic signed [OUT_WIDTH-1:0] dout_q, dout_d;
    logic                        out_valid_q;
    logic                        sat_d;
    logic                        adv;

    logic signed [ACC_W:0] root_ext;
    logic signed [ACC_W:0] res;

    // The whole pipeline advances unless the output holds an unaccepted result.
    assign adv      = ~(out_valid_q & ~out_ready);
    assign in_ready = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NODE_NUM; i++) node_q[i] <= '0;
        end else if (adv) begin
            for (int k = 0; k < INPUT_NUM; k++) begin
                node_q[LEAF_BASE+k] <= ACC_W'($signed(din[k*IN_WIDTH +: IN_WIDTH]));
            end
            // Padding leaves stay zero so they never pollute the sum.
            for (int k = INPUT_NUM; k < LEAF_NUM; k++) node_q[LEAF_BASE+k] <= '0;
            for (int j = 0; j < LEAF_BASE; j++) begin
                node_q[j] <= node_q[2*j+1] + node_q[2*j+2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= STAGE_NUM; s++) mode_q[s] <= 2'd0;
            valid_q <= '0;
        end else if (adv) begin
            mode_q[0] <= mode;
            for (int s = 1; s <= STAGE_NUM; s++) mode_q[s] <= mode_q[s-1];
            valid_q <= {valid_q[STAGE_NUM-1:0], in_valid};
        end
    end

    // Mode handling is done one bit wider than the tree so |-2^(ACC_W-1)| is exact.
    always_comb begin
        root_ext = {node_q[0][ACC_W-1], node_q[0]};
        case (mode_q[STAGE_NUM])
            2'd1:    res = root_ext[ACC_W] ? -root_ext : root_ext;
            2'd2:    res = root_ext >>> SHIFT;
            default: res = root_ext;
        endcase
    end

`ifdef ADDER_TREE_STREAM_SAT_EN
    localparam logic signed [ACC_W:0] SAT_MAX =
        $signed({1'b0, {ACC_W{1'b1}}} >> (ACC_W + 1 - OUT_WIDTH));
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    logic sat_q;

    always_comb begin
        dout_d = OUT_WIDTH'(res);
        sat_d  = 1'b0;
        if (res > SAT_MAX) begin
            dout_d = OUT_WIDTH'(SAT_MAX);
            sat_d  = 1'b1;
        end else if (res < SAT_MIN) begin
            dout_d = OUT_WIDTH'(SAT_MIN);
            sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (adv && valid_q[STAGE_NUM]) begin
            sat_q <= sat_d;
        end
    end

    assign out_sat = sat_q;
`else
    always_comb begin
        dout_d = OUT_WIDTH'(res);
        sat_d  = 1'b0;
    end

    assign out_sat = sat_d;
`endif

    // dout only updates on a valid result, so bubbles leave it at its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            out_valid_q <= valid_q[STAGE_NUM];
            if (valid_q[STAGE_NUM]) dout_q <= dout_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;

endmodule
